// File: rtl/dino_game_pkg.sv
// dino_game_pkg
// Shared definitions for the dino runner game controller: the game state
// encoding, the default geometry/physics constants used as parameter
// defaults by dino_game_ctrl, the scroll speed cap applied when the
// DINO_SPEEDUP_EN build option is defined, and a helper that widens
// 12-bit pixel coordinates onto the 32-bit coordinate outputs.

package dino_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_JUMP = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    // Default geometry and physics (pixels, pixels/frame).
    localparam int DEF_DINO_X       = 100;
    localparam int DEF_GROUND_Y     = 320;
    localparam int DEF_OBST_START_X = 680;
    localparam int DEF_JUMP_V0      = 16;
    localparam int DEF_SCROLL_SPEED = 4;

    // Upper bound of the scroll step when speed-up is enabled.
    localparam int SPEED_CAP = 12;

    // Internal width of every pixel coordinate.
    localparam int COORD_W = 12;

    function automatic logic [31:0] zext_coord(input logic [COORD_W-1:0] coord);
        return {{(32 - COORD_W){1'b0}}, coord};
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge
// Brings a raw asynchronous push-button into the clk domain through a
// two-flop synchronizer and turns each rising edge into a single-cycle
// press pulse.
//
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   btn    in   raw button level (asynchronous)
//   press  out  1-clk pulse on each synchronized rising edge of btn

module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic sync_meta;
    logic sync_stable;
    logic sync_prev;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta   <= 1'b0;
            sync_stable <= 1'b0;
            sync_prev   <= 1'b0;
        end else begin
            sync_meta   <= btn;
            sync_stable <= sync_meta;
            sync_prev   <= sync_stable;
        end
    end

    // Only flop outputs feed this gate, so the pulse is glitch-free.
    assign press = sync_stable & ~sync_prev;

endmodule

// File: rtl/dino_game_ctrl.sv
// dino_game_ctrl
// Game-logic controller for the dino runner: button conditioning, the
// IDLE/RUN/JUMP/OVER state machine, jump physics, obstacle scrolling and
// respawn, and the score. All game motion advances once per video frame,
// on the rising edge of screen_end.
//
// Build option: define DINO_SPEEDUP_EN to raise the scroll step by one
// pixel/frame each time the score reaches a multiple of 8 (capped at
// SPEED_CAP); without it the step stays at SCROLL_SPEED.
//
// Ports:
//   clk                   in   100 MHz system clock
//   reset                 in   asynchronous active-low reset
//   screen_end            in   frame-boundary level from the VGA timing
//   collision_detected    in   dino/obstacle overlap from the renderer
//   jump_btn, start_btn   in   raw push-buttons
//   x_coor, y_coor        out  dino position (12-bit, zero-extended)
//   x_coor_obstacle,
//   y_coor_obstacle       out  obstacle position (12-bit, zero-extended)
//   random_generator_clk  out  2'b11 for one clk on each obstacle respawn
//   score                 out  obstacles cleared, saturating
//   game_over             out  high while in OVER

module dino_game_ctrl
    import dino_game_pkg::*;
#(
    parameter int DINO_X       = DEF_DINO_X,
    parameter int GROUND_Y     = DEF_GROUND_Y,
    parameter int OBST_START_X = DEF_OBST_START_X,
    parameter int JUMP_V0      = DEF_JUMP_V0,
    parameter int SCROLL_SPEED = DEF_SCROLL_SPEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        screen_end,
    input  logic        collision_detected,
    input  logic        jump_btn,
    input  logic        start_btn,
    output logic [31:0] x_coor,
    output logic [31:0] y_coor,
    output logic [31:0] x_coor_obstacle,
    output logic [31:0] y_coor_obstacle,
    output logic [1:0]  random_generator_clk,
    output logic [15:0] score,
    output logic        game_over
);

    // Signed width for the jump arithmetic: room for a 12-bit y plus the
    // sign and one bit of headroom when vel is negative.
    localparam int YW = COORD_W + 2;

    localparam logic [COORD_W-1:0]  DINO_X_C     = COORD_W'(DINO_X);
    localparam logic [COORD_W-1:0]  GROUND_Y_C   = COORD_W'(GROUND_Y);
    localparam logic [COORD_W-1:0]  OBST_START_C = COORD_W'(OBST_START_X);
    localparam logic [COORD_W-1:0]  SCROLL_C     = COORD_W'(SCROLL_SPEED);
    localparam logic signed [7:0]   JUMP_V0_C    = 8'(JUMP_V0);
    localparam logic signed [YW-1:0] GROUND_S    = YW'(GROUND_Y);

    logic                    jump_press;
    logic                    start_press;
    logic                    screen_end_q;
    logic                    frame_tick;

    game_state_t             state;
    logic [COORD_W-1:0]      dino_y;
    logic [COORD_W-1:0]      obst_x;
    logic [COORD_W-1:0]      scroll_step;
    logic signed [7:0]       vel;
    logic                    jump_pending;

    logic                    in_play;
    logic                    restart;
    logic                    move_tick;
    logic                    respawn;
    logic                    score_inc;
    logic signed [YW-1:0]    y_calc;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    btn_sync_edge u_jump_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (jump_btn),
        .press (jump_press)
    );

    btn_sync_edge u_start_sync (
        .clk   (clk),
        .reset (reset),
        .btn   (start_btn),
        .press (start_press)
    );

    // ------------------------------------------------------------------
    // Frame tick: screen_end stays high for several clks, so only its
    // rising edge may advance the game.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            screen_end_q <= 1'b0;
        end else begin
            screen_end_q <= screen_end;
        end
    end

    assign frame_tick = screen_end & ~screen_end_q;

    // ------------------------------------------------------------------
    // Per-tick decisions
    // ------------------------------------------------------------------
    assign in_play   = (state == ST_RUN) || (state == ST_JUMP);
    assign restart   = start_press && ((state == ST_IDLE) || (state == ST_OVER));
    // A collision on a tick pre-empts all movement on that tick.
    assign move_tick = frame_tick && in_play && !collision_detected;
    assign respawn   = move_tick && (obst_x < scroll_step);
    assign score_inc = respawn && (score != 16'hFFFF);

    // y grows downwards, so a positive (upward) vel decreases y.
    assign y_calc = $signed({2'b00, dino_y}) - $signed({{(YW - 8){vel[7]}}, vel});

    // ------------------------------------------------------------------
    // Scroll step
    // ------------------------------------------------------------------
`ifdef DINO_SPEEDUP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scroll_step <= SCROLL_C;
        end else if (restart) begin
            scroll_step <= SCROLL_C;
        end else if (score_inc && (score[2:0] == 3'b111)
                     && (scroll_step < COORD_W'(SPEED_CAP))) begin
            // score is about to become a multiple of 8
            scroll_step <= scroll_step + 1'b1;
        end
    end
`else
    assign scroll_step = SCROLL_C;
`endif

    // ------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                <= ST_IDLE;
            dino_y               <= GROUND_Y_C;
            obst_x               <= OBST_START_C;
            score                <= 16'd0;
            vel                  <= 8'sd0;
            jump_pending         <= 1'b0;
            random_generator_clk <= 2'b00;
            game_over            <= 1'b0;
        end else begin
            // Respawn pulse lasts exactly the clk after the respawning tick.
            random_generator_clk <= 2'b00;

            case (state)
                ST_IDLE, ST_OVER: begin
                    // A frame tick arriving with the start press is
                    // deliberately dropped: motion starts on the next tick.
                    if (restart) begin
                        state        <= ST_RUN;
                        dino_y       <= GROUND_Y_C;
                        obst_x       <= OBST_START_C;
                        score        <= 16'd0;
                        vel          <= 8'sd0;
                        jump_pending <= 1'b0;
                        game_over    <= 1'b0;
                    end
                end

                ST_RUN, ST_JUMP: begin
                    if (state == ST_RUN && jump_press) begin
                        jump_pending <= 1'b1;
                    end

                    if (frame_tick && collision_detected) begin
                        state        <= ST_OVER;
                        game_over    <= 1'b1;
                        jump_pending <= 1'b0;
                    end else if (move_tick) begin
                        if (respawn) begin
                            obst_x               <= OBST_START_C;
                            random_generator_clk <= 2'b11;
                            if (score_inc) begin
                                score <= score + 16'd1;
                            end
                        end else begin
                            obst_x <= obst_x - scroll_step;
                        end

                        if (state == ST_RUN) begin
                            // Launch tick: velocity loads now, y starts
                            // moving on the following tick.
                            if (jump_pending) begin
                                vel          <= JUMP_V0_C;
                                state        <= ST_JUMP;
                                jump_pending <= 1'b0;
                            end
                        end else if (y_calc >= GROUND_S) begin
                            dino_y <= GROUND_Y_C;
                            vel    <= 8'sd0;
                            state  <= ST_RUN;
                        end else if (y_calc[YW-1]) begin
                            // Above the top of the screen: pin to row 0.
                            dino_y <= '0;
                            vel    <= vel - 8'sd1;
                        end else begin
                            dino_y <= y_calc[COORD_W-1:0];
                            vel    <= vel - 8'sd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Coordinate outputs
    // ------------------------------------------------------------------
    assign x_coor          = zext_coord(DINO_X_C);
    assign y_coor          = zext_coord(dino_y);
    assign x_coor_obstacle = zext_coord(obst_x);
    assign y_coor_obstacle = zext_coord(GROUND_Y_C);

endmodule

// File: tb/tb_dino_game_ctrl.sv
// tb_dino_game_ctrl
// Self-checking bench for dino_game_ctrl. A behavioural model tracks the
// game in plain arithmetic (closed-form jump height, obstacle distance,
// respawn count) and is compared against the DUT after every action.

module tb_dino_game_ctrl;

    localparam int DINO_X       = 100;
    localparam int GROUND_Y     = 320;
    localparam int OBST_START_X = 680;
    localparam int JUMP_V0      = 16;
    localparam int SCROLL_SPEED = 4;
    localparam int SPEED_CAP    = 12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        screen_end = 1'b0;
    logic        collision_detected = 1'b0;
    logic        jump_btn = 1'b0;
    logic        start_btn = 1'b0;
    logic [31:0] x_coor;
    logic [31:0] y_coor;
    logic [31:0] x_coor_obstacle;
    logic [31:0] y_coor_obstacle;
    logic [1:0]  random_generator_clk;
    logic [15:0] score;
    logic        game_over;

    always #5 clk = ~clk;

    dino_game_ctrl dut (
        .clk                  (clk),
        .reset                (reset),
        .screen_end           (screen_end),
        .collision_detected   (collision_detected),
        .jump_btn             (jump_btn),
        .start_btn            (start_btn),
        .x_coor               (x_coor),
        .y_coor               (y_coor),
        .x_coor_obstacle      (x_coor_obstacle),
        .y_coor_obstacle      (y_coor_obstacle),
        .random_generator_clk (random_generator_clk),
        .score                (score),
        .game_over            (game_over)
    );

    int total = 0;
    int bad   = 0;

    // Observed respawn pulses: number of clks with a non-zero pulse output,
    // and how many of those were not 2'b11.
    int pulse_cycles = 0;
    int odd_pulses   = 0;

    always @(negedge clk) begin
        if (random_generator_clk != 2'b00) begin
            pulse_cycles++;
            if (random_generator_clk != 2'b11) odd_pulses++;
        end
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef enum {M_IDLE, M_RUN, M_JUMP, M_OVER} mstate_t;

    mstate_t m_state = M_IDLE;
    int      m_y = GROUND_Y;
    int      m_ox = OBST_START_X;
    int      m_score = 0;
    int      m_k = 0;          // ticks spent airborne
    bit      m_pend = 1'b0;
    int      m_respawns = 0;

    function automatic int m_step();
`ifdef DINO_SPEEDUP_EN
        int s;
        s = SCROLL_SPEED + m_score / 8;
        return (s > SPEED_CAP) ? SPEED_CAP : s;
`else
        return SCROLL_SPEED;
`endif
    endfunction

    function automatic void m_reset();
        m_state = M_IDLE;
        m_y     = GROUND_Y;
        m_ox    = OBST_START_X;
        m_score = 0;
        m_k     = 0;
        m_pend  = 1'b0;
    endfunction

    function automatic void m_start();
        if (m_state == M_IDLE || m_state == M_OVER) begin
            m_state = M_RUN;
            m_y     = GROUND_Y;
            m_ox    = OBST_START_X;
            m_score = 0;
            m_k     = 0;
            m_pend  = 1'b0;
        end
    endfunction

    function automatic void m_jump();
        if (m_state == M_RUN) m_pend = 1'b1;
    endfunction

    function automatic void m_tick(input bit coll);
        int step;
        int height;
        if (m_state == M_RUN || m_state == M_JUMP) begin
            if (coll) begin
                m_state = M_OVER;
                m_pend  = 1'b0;
            end else begin
                step = m_step();
                if (m_ox < step) begin
                    m_ox = OBST_START_X;
                    if (m_score < 65535) m_score++;
                    m_respawns++;
                end else begin
                    m_ox = m_ox - step;
                end
                if (m_state == M_RUN) begin
                    if (m_pend) begin
                        m_state = M_JUMP;
                        m_k     = 0;
                        m_pend  = 1'b0;
                    end
                end else begin
                    m_k++;
                    // Height after k ticks of a ballistic jump.
                    height = JUMP_V0 * m_k - (m_k * (m_k - 1)) / 2;
                    if (GROUND_Y - height >= GROUND_Y) begin
                        m_y     = GROUND_Y;
                        m_state = M_RUN;
                        m_k     = 0;
                    end else begin
                        m_y = GROUND_Y - height;
                    end
                end
            end
        end
    endfunction

    function automatic logic [208:0] exp_vec();
        return {32'(DINO_X), 32'(m_y), 32'(m_ox), 32'(GROUND_Y), 16'(m_score),
                (m_state == M_OVER) ? 1'b1 : 1'b0, 32'(m_respawns), 32'd0};
    endfunction

    function automatic logic [208:0] act_vec();
        return {x_coor, y_coor, x_coor_obstacle, y_coor_obstacle, score,
                game_over, 32'(pulse_cycles), 32'(odd_pulses)};
    endfunction

    // ------------------------------------------------------------------
    // Stimulus drivers (all bench actions start and end on a negedge)
    // ------------------------------------------------------------------
    task automatic tick(input bit coll, input int hold);
        @(negedge clk);
        screen_end         = 1'b1;
        collision_detected = coll;
        @(negedge clk);
        collision_detected = 1'b0;
        repeat (hold - 1) @(negedge clk);
        screen_end = 1'b0;
        repeat (2) @(negedge clk);
        m_tick(coll);
    endtask

    task automatic press(input bit is_start);
        @(negedge clk);
        if (is_start) start_btn = 1'b1; else jump_btn = 1'b1;
        repeat (3) @(negedge clk);
        start_btn = 1'b0;
        jump_btn  = 1'b0;
        repeat (3) @(negedge clk);
        if (is_start) m_start(); else m_jump();
    endtask

    // Button press whose synchronized pulse lands on the same clk as a
    // frame tick (two synchronizer stages after the button rises).
    task automatic press_on_tick(input bit is_start, input bit coll);
        @(negedge clk);
        if (is_start) start_btn = 1'b1; else jump_btn = 1'b1;
        repeat (2) @(negedge clk);
        screen_end         = 1'b1;
        collision_detected = coll;
        @(negedge clk);
        collision_detected = 1'b0;
        start_btn          = 1'b0;
        jump_btn           = 1'b0;
        repeat (3) @(negedge clk);
        screen_end = 1'b0;
        repeat (3) @(negedge clk);
        if (is_start) begin
            m_start();
        end else begin
            m_jump();
            m_tick(coll);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        screen_end = 1'b0;
        collision_detected = 1'b0;
        jump_btn = 1'b0;
        start_btn = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        m_reset();
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        m_reset();
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_low: got %h want %h", act_vec(), exp_vec());
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_release: got %h want %h", act_vec(), exp_vec());
        end
        press(1'b0);
        tick(1'b0, 3);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL idle_ignores_jump_tick: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_start();
        press(1'b1);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL start_press: got %h want %h", act_vec(), exp_vec());
        end
        // screen_end held 4 clks per frame: one step per frame only.
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 4);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL start_tick%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (x_coor_obstacle !== 32'd640 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL start_obstacle_640: got x=%0d go=%0b want x=640 go=0",
                     x_coor_obstacle, game_over);
        end
    endtask

    task automatic test_jump();
        press(1'b0);
        tick(1'b0, 2);   // launch tick: y still on the ground
        total++;
        if (act_vec() !== exp_vec() || y_coor !== 32'd320) begin
            bad++;
            $display("FAIL jump_launch: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 1; i <= 33; i++) begin
            if (i == 5) begin
                press(1'b0);  // ignored while airborne
                press(1'b1);  // ignored while playing
            end
            tick(1'b0, $urandom_range(6, 1));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL jump_tick%0d: got %h want %h", i, act_vec(), exp_vec());
            end
            if (i == 1 || i == 16 || i == 17 || i == 33) begin
                total++;
                if (y_coor !== ((i == 1) ? 32'd304 : (i == 33) ? 32'd320 : 32'd184)) begin
                    bad++;
                    $display("FAIL jump_y_at_tick%0d: got %0d", i, y_coor);
                end
            end
        end
        // Back on the ground: a fresh jump must launch again.
        press(1'b0);
        tick(1'b0, 1);
        tick(1'b0, 1);
        total++;
        if (y_coor !== 32'd304 || act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL jump_again: got y=%0d want 304", y_coor);
        end
        for (int i = 2; i <= 33; i++) tick(1'b0, 1);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL jump_again_land: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_respawn();
        int p0;
        apply_reset();
        press(1'b1);
        p0 = pulse_cycles;
        for (int i = 1; i <= 171; i++) begin
            tick(1'b0, $urandom_range(6, 1));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL respawn_tick%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        total++;
        if (x_coor_obstacle !== 32'd680 || score !== 16'd1 || pulse_cycles - p0 !== 1) begin
            bad++;
            $display("FAIL respawn_171: got x=%0d score=%0d pulses=%0d want 680 1 1",
                     x_coor_obstacle, score, pulse_cycles - p0);
        end
    endtask

    task automatic test_crash();
        for (int i = 0; i < 5; i++) tick(1'b0, 2);
        press_on_tick(1'b0, 1'b1);
        total++;
        if (act_vec() !== exp_vec() || game_over !== 1'b1) begin
            bad++;
            $display("FAIL crash_with_jump: got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 3; i++) begin
            press(1'b0);
            tick(1'($urandom_range(1, 0)), $urandom_range(6, 1));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL crash_frozen%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        press(1'b1);
        total++;
        if (act_vec() !== exp_vec() || score !== 16'd0 || game_over !== 1'b0) begin
            bad++;
            $display("FAIL crash_restart: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_restart_on_tick();
        for (int i = 0; i < 3; i++) tick(1'b0, 3);
        tick(1'b1, 3);
        press_on_tick(1'b1, 1'b0);
        total++;
        if (act_vec() !== exp_vec() || x_coor_obstacle !== 32'd680) begin
            bad++;
            $display("FAIL restart_on_tick: got %h want %h", act_vec(), exp_vec());
        end
        tick(1'b0, 2);
        total++;
        if (x_coor_obstacle !== 32'd676 || act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL restart_first_move: got x=%0d want 676", x_coor_obstacle);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(9, 0);
            if (sel <= 5)      tick(1'($urandom_range(29, 0) == 0), $urandom_range(6, 1));
            else if (sel <= 7) press(1'b0);
            else if (sel == 8) press(1'b1);
            else               tick(1'b0, 1);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_step%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        press(1'b1);
        for (int i = 0; i < 170; i++) tick(1'b0, 1);
        // The next tick would respawn; reset lands on that frame instead.
        @(negedge clk);
        screen_end = 1'b1;
        reset      = 1'b0;
        repeat (2) @(negedge clk);
        screen_end = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        m_reset();
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_mid_frame: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_jump();
        test_respawn();
        test_crash();
        test_restart_on_tick();
        test_random();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
